// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: bus structs, FSM state,
// default geometry and the address-field typedefs derived from it.
package icache_pkg;

  // Bus definitions shared with the rest of the fetch path.
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP} axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_BEATS = 4;
  localparam int ICACHE_IB         = $clog2(ICACHE_SETS);
  localparam int ICACHE_OB         = 3 + $clog2(ICACHE_LINE_BEATS);
  localparam int ICACHE_TW         = 64 - ICACHE_OB - ICACHE_IB;

  typedef logic [ICACHE_IB-1:0] index_t;
  typedef logic [ICACHE_TW-1:0] tag_t;
  typedef logic [ICACHE_OB-1:0] offset_t;

  typedef enum logic {IDLE, REFILL} icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side (ibus) and memory-side (cbus) signals of the instruction cache.
interface icache_direct_if;
  import icache_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  // master: the surrounding core/arbiter; slave: the cache itself
  modport master (output ireq, cresp, input iresp, creq);
  modport slave  (input ireq, cresp, output iresp, creq);
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped cache. Async read of a whole line,
// per-beat data writes, and a commit port that sets or clears a line's valid bit.
module icache_array
  import icache_pkg::*;
#(
  parameter  int SETS       = ICACHE_SETS,
  parameter  int LINE_BEATS = ICACHE_LINE_BEATS,
  localparam int IB         = $clog2(SETS),
  localparam int BW         = $clog2(LINE_BEATS),
  localparam int TW         = 64 - 3 - BW - IB
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IB-1:0]                rd_idx,
  output logic                         rd_valid,
  output logic [TW-1:0]                rd_tag,
  output logic [LINE_BEATS-1:0][63:0]  rd_line,
  input  logic                         wr_en,
  input  logic [IB-1:0]                wr_idx,
  input  logic [BW-1:0]                wr_beat,
  input  logic [63:0]                  wr_data,
  input  logic                         commit_en,
  input  logic                         commit_valid,
  input  logic [IB-1:0]                commit_idx,
  input  logic [TW-1:0]                commit_tag
);

  logic [SETS-1:0]                valid;
  logic [TW-1:0]                  tag_arr  [SETS];
  logic [LINE_BEATS-1:0][63:0]    data_arr [SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_line  = data_arr[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         valid <= '0;
    else if (commit_en) valid[commit_idx] <= commit_valid;
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (commit_en && commit_valid) tag_arr[commit_idx] <= commit_tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_arr[wr_idx][wr_beat] <= wr_data;
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, one INCR burst refill
// per miss, after which the pending fetch hits out of the freshly installed line.
module icache_direct
  import icache_pkg::*;
#(
  parameter int SETS       = ICACHE_SETS,
  parameter int LINE_BEATS = ICACHE_LINE_BEATS
) (
  input  logic                   clk,
  input  logic                   reset,
  icache_direct_if.slave         bus,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  localparam int IB = $clog2(SETS);
  localparam int BW = $clog2(LINE_BEATS);
  localparam int OB = 3 + BW;
  localparam int TW = 64 - OB - IB;

  icache_state_t  state;
  logic [63:0]    raddr;
  logic [BW-1:0]  cnt;

  logic [IB-1:0]  idx, ridx;
  logic [TW-1:0]  tag, rtag;
  logic [BW-1:0]  word;
  logic           rd_valid;
  logic [TW-1:0]  rd_tag;
  logic [LINE_BEATS-1:0][63:0] rd_line;
  logic [63:0]    sel_beat;
  logic           hit, miss, accept, done, full;
  logic           unused_addr;

  assign idx         = bus.ireq.addr[OB+IB-1:OB];
  assign tag         = bus.ireq.addr[63:OB+IB];
  assign word        = bus.ireq.addr[OB-1:3];
  assign ridx        = raddr[OB+IB-1:OB];
  assign rtag        = raddr[63:OB+IB];
  assign unused_addr = ^bus.ireq.addr[1:0];

  assign hit    = (state == IDLE) && bus.ireq.valid && rd_valid && (rd_tag == tag);
  assign miss   = (state == IDLE) && bus.ireq.valid && !hit;
  assign accept = (state == REFILL) && bus.cresp.ready;
  assign full   = accept && (cnt == BW'(LINE_BEATS-1));
  // An early last ends the burst without validating the line.
  assign done   = accept && (bus.cresp.last || (cnt == BW'(LINE_BEATS-1)));

  icache_array #(.SETS(SETS), .LINE_BEATS(LINE_BEATS)) u_array (
    .clk          (clk),
    .reset        (reset),
    .rd_idx       (idx),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_line      (rd_line),
    .wr_en        (accept),
    .wr_idx       (ridx),
    .wr_beat      (cnt),
    .wr_data      (bus.cresp.data),
    .commit_en    (miss || full),
    .commit_valid (full),
    .commit_idx   (full ? ridx : idx),
    .commit_tag   (rtag)
  );

  assign sel_beat = rd_line[word];

  always_comb begin
    bus.iresp = '0;
    if (hit) begin
      bus.iresp.addr_ok = 1'b1;
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = bus.ireq.addr[2] ? sel_beat[63:32] : sel_beat[31:0];
    end
  end

  // Request fields come only from state/raddr, so they hold across stalls.
  always_comb begin
    bus.creq = '0;
    if (state == REFILL) begin
      bus.creq.valid = 1'b1;
      bus.creq.size  = MSIZE8;
      bus.creq.addr  = raddr;
      bus.creq.len   = 8'(LINE_BEATS-1);
      bus.creq.burst = AXI_BURST_INCR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      raddr    <= '0;
      cnt      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
          if (miss) begin
            raddr <= {bus.ireq.addr[63:OB], {OB{1'b0}}};
            cnt   <= '0;
            state <= REFILL;
            if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
          end
        end
        REFILL: begin
          if (accept) cnt <= cnt + BW'(1);
          if (done)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
